// File: rtl/regn_pipe.sv
// Elastic pipeline register: DEPTH n-bit stages with per-stage valids, valid/ready
// on both sides, flush, bubble collapsing and a registered occupancy count.
// The output data port is do_data because "do" is a reserved word in SystemVerilog.
module regn_pipe #(
  parameter int n     = 32,
  parameter int DEPTH = 3,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [n-1:0]  di,
  input  logic          di_valid,
  output logic          di_ready,
  output logic [n-1:0]  do_data,
  output logic          do_valid,
  input  logic          do_ready,
  output logic [CW-1:0] count
);

  logic [n-1:0]     data   [DEPTH];
  logic [n-1:0]     prev_d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] prev_v;
  logic [DEPTH-1:0] adv;
  logic             go;
  logic             in_xfer;
  logic             out_xfer;

  // adv[i] = !v[i] || adv[i+1], unrolled from the output side through a running
  // term so the vector never feeds back on itself.
  always_comb begin
    adv = '0;
    go  = do_ready;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      go                = go || !v[DEPTH-1-j];
      adv[DEPTH-1-j]    = go;
    end
  end

  always_comb begin
    prev_d[0] = di;
    prev_v[0] = di_valid;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      prev_d[i] = data[i-1];
      prev_v[i] = v[i-1];
    end
  end

  assign di_ready = adv[0];
  assign do_data  = data[DEPTH-1];
  assign do_valid = v[DEPTH-1];
  assign in_xfer  = di_valid && adv[0];
  assign out_xfer = v[DEPTH-1] && do_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v     <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data[i] <= '0;
    end else if (flush) begin
      v     <= '0;
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          v[i] <= prev_v[i];
          // Data only moves with a valid word, so bubbles never toggle the registers.
          if (prev_v[i]) data[i] <= prev_d[i];
        end
      end
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_regn_pipe.sv
// Bench for regn_pipe (n=32, DEPTH=3): per-cycle vector table, hand-written corner
// sequences, and a queue scoreboard running underneath all of them.
module tb_regn_pipe;
  localparam int N  = 32;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  di = '0;
  logic          di_valid = 1'b0;
  logic          di_ready;
  logic [N-1:0]  do_data;
  logic          do_valid;
  logic          do_ready = 1'b0;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] q[$];

  regn_pipe #(.n(N), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .di(di), .di_valid(di_valid), .di_ready(di_ready),
    .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: sampled mid-cycle, where inputs and outputs are settled for the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("sb_count", 64'(count), 64'(q.size()));
      chk("sb_di_ready", 64'(di_ready), 64'(!(q.size() == D && !do_ready)));
      if (do_valid && do_ready) begin
        if (q.size() == 0) chk("sb_spurious_out", 64'(do_data), 64'hDEAD_0000);
        else chk("sb_data", 64'(do_data), 64'(q.pop_front()));
      end
      if (flush) q.delete();
      else if (di_valid && di_ready) q.push_back(di);
    end
  end

  typedef struct {
    bit          vld;
    bit [N-1:0]  d;
    bit          rdy;
    bit          xrdy;
    bit          xvld;
    bit [N-1:0]  xdo;
    bit [CW-1:0] xcnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(int vld, int d, int rdy, int xrdy, int xvld, int xdo, int xcnt);
    vec_t r;
    r.vld = vld[0]; r.d = N'(d); r.rdy = rdy[0];
    r.xrdy = xrdy[0]; r.xvld = xvld[0]; r.xdo = N'(xdo); r.xcnt = CW'(xcnt);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string name);
    chk({name, "_do"}, 64'(do_data), 64'h0);
    chk({name, "_do_valid"}, 64'(do_valid), 64'h0);
    chk({name, "_count"}, 64'(count), 64'h0);
    chk({name, "_di_ready"}, 64'(di_ready), 64'h1);
  endtask

  logic [N-1:0] prev_do;
  logic         prev_stall;

  initial begin
    // Streaming: 11..44 back-to-back, then draining (data holds on bubbles).
    tbl[0]  = mk(1, 'h11, 1, 1, 0, 'h00, 0);
    tbl[1]  = mk(1, 'h22, 1, 1, 0, 'h00, 1);
    tbl[2]  = mk(1, 'h33, 1, 1, 0, 'h00, 2);
    tbl[3]  = mk(1, 'h44, 1, 1, 1, 'h11, 3);
    tbl[4]  = mk(0, 'h00, 1, 1, 1, 'h22, 3);
    tbl[5]  = mk(0, 'h00, 1, 1, 1, 'h33, 2);
    tbl[6]  = mk(0, 'h00, 1, 1, 1, 'h44, 1);
    tbl[7]  = mk(0, 'h00, 1, 1, 0, 'h44, 0);
    // Back-pressure: fill A0..A2, stall with A3 waiting, release one cycle, drain.
    tbl[8]  = mk(1, 'hA0, 0, 1, 0, 'h44, 0);
    tbl[9]  = mk(1, 'hA1, 0, 1, 0, 'h44, 1);
    tbl[10] = mk(1, 'hA2, 0, 1, 0, 'h44, 2);
    tbl[11] = mk(1, 'hA3, 0, 0, 1, 'hA0, 3);
    tbl[12] = mk(1, 'hA3, 0, 0, 1, 'hA0, 3);
    tbl[13] = mk(1, 'hA3, 1, 1, 1, 'hA0, 3);
    tbl[14] = mk(0, 'h00, 0, 0, 1, 'hA1, 3);
    tbl[15] = mk(0, 'h00, 1, 1, 1, 'hA1, 3);
    tbl[16] = mk(0, 'h00, 1, 1, 1, 'hA2, 2);
    tbl[17] = mk(0, 'h00, 1, 1, 1, 'hA3, 1);
    tbl[18] = mk(0, 'h00, 1, 1, 0, 'hA3, 0);

    // Reset / idle
    #1;
    cyc(); idle_chk("rst1");
    cyc(); idle_chk("rst2");
    rst_n = 1'b1;
    #1; idle_chk("rst_rel");
    cyc(); idle_chk("idle1");

    for (int i = 0; i < 19; i++) begin
      di_valid = tbl[i].vld; di = tbl[i].d; do_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_di_ready", i), 64'(di_ready), 64'(tbl[i].xrdy));
      chk($sformatf("vec%0d_do_valid", i), 64'(do_valid), 64'(tbl[i].xvld));
      chk($sformatf("vec%0d_do", i), 64'(do_data), 64'(tbl[i].xdo));
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].xcnt));
      cyc();
    end

    // Bubble collapse: 5, two idle cycles, 6, stalled output.
    do_ready = 1'b0;
    di_valid = 1'b1; di = 'h5; cyc();
    di_valid = 1'b0; cyc(); cyc();
    di_valid = 1'b1; di = 'h6; cyc();
    di_valid = 1'b0; cyc(); cyc();
    #1;
    chk("bub_count", 64'(count), 64'h2);
    chk("bub_di_ready", 64'(di_ready), 64'h1);
    do_ready = 1'b1;
    #1;
    chk("bub_out0_vld", 64'(do_valid), 64'h1);
    chk("bub_out0", 64'(do_data), 64'h5);
    cyc();
    chk("bub_out1_vld", 64'(do_valid), 64'h1);
    chk("bub_out1", 64'(do_data), 64'h6);
    cyc();
    chk("bub_empty", 64'(do_valid), 64'h0);

    // Flush with two words inside and 0x77 offered the same cycle.
    do_ready = 1'b0;
    di_valid = 1'b1; di = 'h71; cyc();
    di = 'h72; cyc();
    di = 'h77; flush = 1'b1; cyc();
    flush = 1'b0; di_valid = 1'b0;
    #1;
    chk("fl_count", 64'(count), 64'h0);
    chk("fl_do_valid", 64'(do_valid), 64'h0);
    do_ready = 1'b1;
    for (int i = 0; i < D + 2; i++) begin
      cyc();
      chk($sformatf("fl_quiet%0d", i), 64'(do_valid), 64'h0);
    end

    // Reset while full and stalled.
    do_ready = 1'b0; di_valid = 1'b1;
    for (int i = 0; i < D; i++) begin di = 32'hB0 + 32'(i); cyc(); end
    di = 'hB3;
    #1; chk("rm_full", 64'(count), 64'(D));
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; di_valid = 1'b0;
    #1; idle_chk("rm_after");
    do_ready = 1'b1;
    for (int i = 0; i < D + 2; i++) begin
      cyc();
      chk($sformatf("rm_quiet%0d", i), 64'(do_valid), 64'h0);
    end

    // Random traffic with occasional flush; scoreboard checks data/count/ready,
    // and output stability is checked whenever the previous cycle was stalled.
    prev_stall = 1'b0; prev_do = '0;
    for (int i = 0; i < 400; i++) begin
      di_valid = 1'($urandom_range(0, 1));
      di       = $urandom;
      do_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 29) == 0);
      #1;
      if (prev_stall) begin
        chk("stall_vld", 64'(do_valid), 64'h1);
        chk("stall_do", 64'(do_data), 64'(prev_do));
      end
      prev_stall = do_valid && !do_ready && !flush;
      prev_do    = do_data;
      cyc();
    end
    flush = 1'b0; di_valid = 1'b0; do_ready = 1'b1;
    for (int i = 0; i < D + 2; i++) cyc();
    #1;
    chk("drain_count", 64'(count), 64'h0);
    chk("drain_sb_empty", 64'(q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
